// File: rtl/bram_readout_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_readout_if : control, BRAM port-B and byte-stream signals       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface bram_readout_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 13
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    input  start, base_addr, length, doutb, m_ready,
    output busy, done, enb, addrb, m_data, m_valid
  );

  modport slave (
    output start, base_addr, length, doutb, m_ready,
    input  busy, done, enb, addrb, m_data, m_valid
  );
endinterface
`default_nettype wire

// File: rtl/bram_readout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_readout_ctrl : BRAM port-B burst reader with 2-entry skid buffer |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module bram_readout_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 13
) (
  input  wire logic      clk,
  input  wire logic      rst,
  bram_readout_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_addr_last;
  logic [LEN_W-1:0]  r_rd_left;
  logic [LEN_W-1:0]  r_out_left;
  logic              r_inflight;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;
  logic              w_valid;
  logic              w_pop;
  logic              w_enb;
  logic [1:0]        w_occ_eff;

  assign w_valid = (r_occ != 2'd0);
  assign w_pop   = w_valid && bus.m_ready;

  // Occupancy counts this cycle's pop so a steady stream issues every cycle.
  assign w_occ_eff = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_enb     = (r_state == S_READ) && (r_rd_left != '0) && (w_occ_eff < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (bus.length == '0) ? S_FIN : S_READ;
      end
      S_READ: begin
        if (w_enb && (r_rd_left == LEN_W'(1))) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave as soon as the final handshake happens, not a cycle later.
        if ((r_out_left == '0) || ((r_out_left == LEN_W'(1)) && w_pop)) w_next = S_FIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (r_state != S_IDLE);
    bus.done    = (r_state == S_FIN);
    bus.enb     = w_enb;
    bus.addrb   = w_enb ? r_rd_addr : r_addr_last;
    bus.m_valid = w_valid;
    bus.m_data  = r_rptr ? r_buf1 : r_buf0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr   <= '0;
      r_addr_last <= '0;
      r_rd_left   <= '0;
      r_out_left  <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_enb;
      if ((r_state == S_IDLE) && bus.start && (bus.length != '0)) begin
        r_rd_addr  <= bus.base_addr;
        r_rd_left  <= bus.length;
        r_out_left <= bus.length;
      end else begin
        if (w_enb) begin
          r_rd_addr   <= r_rd_addr + ADDR_W'(1);
          r_rd_left   <= r_rd_left - LEN_W'(1);
          r_addr_last <= r_rd_addr;
        end
        if (w_pop && (r_out_left != '0)) r_out_left <= r_out_left - LEN_W'(1);
      end
    end
  end

  // Read data returns one cycle after enb and lands at the buffer tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (r_inflight) begin
        if (r_wptr) r_buf1 <= bus.doutb;
        else        r_buf0 <= bus.doutb;
        r_wptr <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_readout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_readout_ctrl : directed bench for bram_readout_ctrl           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bram_readout_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] got[$];
  int   stall_err = 0;
  int   occ_err   = 0;
  int   enb_cnt   = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always #5 clk = ~clk;

  bram_readout_if #(.ADDR_W(12), .DATA_W(8), .LEN_W(13)) bus ();

  bram_readout_ctrl #(.ADDR_W(12), .DATA_W(8), .LEN_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM model preloaded with mem[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) begin
    if (bus.enb) bus.doutb <= bus.addrb[7:0];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      if (prev_stall && (bus.m_data !== prev_data)) stall_err++;
      if (dut.r_occ > 2'd2) occ_err++;
      if (bus.enb) enb_cnt++;
    end
    prev_stall = bus.m_valid && !bus.m_ready && !rst;
    prev_data  = bus.m_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start pulse; returns #1 into cycle T+1.
  task automatic launch(input logic [11:0] base, input logic [12:0] len);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!bus.done && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, {31'd0, bus.done}, 32'd1);
    step();
  endtask

  task automatic check_got(input string tag, input int n, input logic [11:0] base);
    logic [11:0] a;
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      check({tag, "_byte"}, (i < got.size()) ? {24'd0, got[i]} : 32'hxxxx_xxxx, {24'd0, a[7:0]});
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.m_ready = 1'b1;

    #3;
    check("rst_busy",  {31'd0, bus.busy},    0);
    check("rst_done",  {31'd0, bus.done},    0);
    check("rst_enb",   {31'd0, bus.enb},     0);
    check("rst_valid", {31'd0, bus.m_valid}, 0);
    check("rst_addrb", {20'd0, bus.addrb},   0);
    check("rst_data",  {24'd0, bus.m_data},  0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step();

    // 1: base 0x010, len 4, exact latency
    got.delete();
    launch(12'h010, 13'd4);
    check("t1_busy_T1",  {31'd0, bus.busy}, 1);
    check("t1_enb_T1",   {31'd0, bus.enb},  1);
    check("t1_addr_T1",  {20'd0, bus.addrb}, 32'h010);
    check("t1_valid_T1", {31'd0, bus.m_valid}, 0);
    step();
    check("t1_valid_T2", {31'd0, bus.m_valid}, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_valid", {31'd0, bus.m_valid}, 1);
      check("t1_data",  {24'd0, bus.m_data},  32'h10 + k);
      check("t1_nodone", {31'd0, bus.done},   0);
    end
    step();
    check("t1_done_T7",  {31'd0, bus.done},    1);
    check("t1_busy_T7",  {31'd0, bus.busy},    1);
    check("t1_valid_T7", {31'd0, bus.m_valid}, 0);
    step();
    check("t1_busy_T8",  {31'd0, bus.busy}, 0);
    check("t1_done_T8",  {31'd0, bus.done}, 0);
    check_got("t1", 4, 12'h010);

    // 2: address wrap FFE..001
    got.delete();
    launch(12'hFFE, 13'd4);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) begin
        check("t2_enb",  {31'd0, bus.enb}, 1);
        check("t2_addr", {20'd0, bus.addrb}, (32'hFFE + k - 1) & 32'hFFF);
      end
      if (k >= 3) check("t2_data", {24'd0, bus.m_data}, (32'hFE + k - 3) & 32'hFF);
      step();
    end
    check("t2_done", {31'd0, bus.done}, 1);
    step();
    check("t2_addr_hold", {20'd0, bus.addrb}, 32'h001);
    check_got("t2", 4, 12'hFFE);

    // 3: backpressure pattern 1,0,0 repeating
    got.delete(); stall_err = 0; occ_err = 0;
    launch(12'h020, 13'd8);
    begin
      int n = 0;
      while (!bus.done && n < 100) begin
        bus.m_ready = (n % 3 == 0);
        step();
        n++;
      end
    end
    check("t3_done", {31'd0, bus.done}, 1);
    bus.m_ready = 1'b1;
    check("t3_valid_at_done", {31'd0, bus.m_valid}, 0);
    step();
    check_got("t3", 8, 12'h020);
    check("t3_stall_stable", stall_err, 0);
    check("t3_occ_le2", occ_err, 0);

    // 4: zero length
    got.delete(); enb_cnt = 0;
    launch(12'h123, 13'd0);
    check("t4_done_T1",  {31'd0, bus.done},    1);
    check("t4_busy_T1",  {31'd0, bus.busy},    1);
    check("t4_enb_T1",   {31'd0, bus.enb},     0);
    check("t4_valid_T1", {31'd0, bus.m_valid}, 0);
    step();
    check("t4_done_T2", {31'd0, bus.done}, 0);
    check("t4_busy_T2", {31'd0, bus.busy}, 0);
    step();
    check("t4_enb_cnt", enb_cnt, 0);
    check("t4_no_bytes", got.size(), 0);

    // 5: start while busy is ignored
    got.delete(); enb_cnt = 0;
    launch(12'h040, 13'd5);
    step();
    bus.start = 1'b1; bus.base_addr = 12'h300; bus.length = 13'd2;
    step();
    bus.start = 1'b0;
    wait_done("t5_done", 40);
    for (int k = 0; k < 4; k++) step();
    check("t5_idle_busy",  {31'd0, bus.busy},    0);
    check("t5_idle_valid", {31'd0, bus.m_valid}, 0);
    check("t5_enb_cnt", enb_cnt, 5);
    check_got("t5", 5, 12'h040);

    // 6: async reset mid-burst, then a fresh burst
    got.delete();
    launch(12'h080, 13'd6);
    for (int k = 0; k < 4; k++) step();
    check("t6_two_bytes", got.size(), 2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy",  {31'd0, bus.busy},    0);
    check("t6_rst_done",  {31'd0, bus.done},    0);
    check("t6_rst_enb",   {31'd0, bus.enb},     0);
    check("t6_rst_valid", {31'd0, bus.m_valid}, 0);
    check("t6_rst_addrb", {20'd0, bus.addrb},   0);
    check("t6_rst_data",  {24'd0, bus.m_data},  0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step();
    got.delete();
    launch(12'h0A0, 13'd3);
    wait_done("t6_done", 40);
    for (int k = 0; k < 3; k++) step();
    check_got("t6", 3, 12'h0A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
